// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the two-port memory arbiter.
//   state_e  - arbiter FSM states
//   owner_e  - which port owns the current access (FETCH=0, DATA=1)
//   ADDR_W_DEF / DATA_W_DEF - default RAM word-address and data widths
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
//   req[0]     in  fetch port request
//   req[1]     in  data port request
//   last_owner in  port served by the most recent acceptance
//   winner     out selected port (only meaningful when any req is high)
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_owner,
  output owner_e     winner
);

  always_comb begin
    winner = OWN_FETCH;
    if (req == 2'b11) begin
      // Contention: the port that was not served last goes next.
      winner = (last_owner == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
    end else if (req[1]) begin
      winner = OWN_DATA;
    end else begin
      winner = OWN_FETCH;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch (read-only) port and a data (read/write)
// port onto a single-ported synchronous RAM, one access every 3 cycles.
//   clk, reset                      clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt/if_ack fetch port
//   d_req/d_we/d_addr/d_wdata -> d_gnt/d_ack  data port
//   rdata                           captured read data, shared by both ports
//   busy                            high whenever the FSM is not IDLE
//   ram_*                           RAM interface (readWrite: 1=read, 0=write)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting; requests are sampled and arbitrated only here
// ST_ACCESS | RAM enabled with latched address/data, winner's gnt high
// ST_RESP   | RAM idle, read data on rdata, owner's ack high
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ram_enable,
  output logic              ram_readWrite,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut
);

  state_e state_q, state_nxt;
  owner_e owner_q, last_owner_q, winner;
  logic   we_q;
  logic   accept;

  logic              if_gnt_nxt, d_gnt_nxt, if_ack_nxt, d_ack_nxt;
  logic              ram_enable_nxt, ram_rw_nxt;
  logic [ADDR_W-1:0] ram_address_nxt;
  logic [DATA_W-1:0] ram_data_in_nxt;
  logic [DATA_W-1:0] rdata_nxt;

  rr_arb2 u_rr_arb2 (
    .req       ({d_req, if_req}),
    .last_owner(last_owner_q),
    .winner    (winner)
  );

  assign accept = (state_q == ST_IDLE) && (if_req || d_req);

  // State register; every output is also registered here from its *_nxt value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_FETCH;
      last_owner_q  <= OWN_FETCH;
      we_q          <= 1'b0;
      if_gnt        <= 1'b0;
      d_gnt         <= 1'b0;
      if_ack        <= 1'b0;
      d_ack         <= 1'b0;
      busy          <= 1'b0;
      ram_enable    <= 1'b0;
      ram_readWrite <= 1'b1;
      ram_address   <= '0;
      ram_dataIn    <= '0;
      rdata         <= '0;
    end else begin
      state_q       <= state_nxt;
      if_gnt        <= if_gnt_nxt;
      d_gnt         <= d_gnt_nxt;
      if_ack        <= if_ack_nxt;
      d_ack         <= d_ack_nxt;
      busy          <= (state_nxt != ST_IDLE);
      ram_enable    <= ram_enable_nxt;
      ram_readWrite <= ram_rw_nxt;
      ram_address   <= ram_address_nxt;
      ram_dataIn    <= ram_data_in_nxt;
      rdata         <= rdata_nxt;
      if (accept) begin
        owner_q      <= winner;
        last_owner_q <= winner;
        we_q         <= (winner == OWN_DATA) ? d_we : 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE:   if (if_req || d_req) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output process computes what the registered outputs show next cycle.
  always_comb begin
    if_gnt_nxt      = 1'b0;
    d_gnt_nxt       = 1'b0;
    if_ack_nxt      = 1'b0;
    d_ack_nxt       = 1'b0;
    ram_enable_nxt  = 1'b0;
    ram_rw_nxt      = 1'b1;
    ram_address_nxt = ram_address;
    ram_data_in_nxt = ram_dataIn;
    rdata_nxt       = rdata;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ram_enable_nxt = 1'b1;
          if (winner == OWN_DATA) begin
            d_gnt_nxt       = 1'b1;
            ram_rw_nxt      = ~d_we;
            ram_address_nxt = d_addr;
            ram_data_in_nxt = d_wdata;
          end else begin
            // Fetch is read-only; ram_dataIn keeps its previous value.
            if_gnt_nxt      = 1'b1;
            ram_address_nxt = if_addr;
          end
        end
      end
      ST_ACCESS: begin
        if (owner_q == OWN_DATA) d_ack_nxt = 1'b1;
        else                     if_ack_nxt = 1'b1;
        if (!we_q) rdata_nxt = ram_dataOut;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          if_gnt, if_ack, d_gnt, d_ack, busy;
  logic          ram_enable, ram_readWrite;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_dataIn, ram_dataOut, rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_gnt       (if_gnt),
    .if_ack       (if_ack),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_gnt        (d_gnt),
    .d_ack        (d_ack),
    .rdata        (rdata),
    .busy         (busy),
    .ram_enable   (ram_enable),
    .ram_readWrite(ram_readWrite),
    .ram_address  (ram_address),
    .ram_dataIn   (ram_dataIn),
    .ram_dataOut  (ram_dataOut)
  );

  // Bench RAM: asynchronous read, write on clock edge when enabled for write.
  logic [DW-1:0] ram [0:65535];
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (ram_enable && !ram_readWrite) ram[ram_address] <= ram_dataIn;
  end
  assign ram_dataOut = ram[ram_address];

  // Reference model state: expected memory contents, last served port, rdata.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  bit            last_served;  // 0 = fetch, 1 = data
  logic [DW-1:0] exp_rdata;
  int            n_pass = 0;
  int            n_total = 0;

  // {if_gnt, d_gnt, if_ack, d_ack, ram_enable, ram_readWrite, busy}
  logic [6:0] st;
  assign st = {if_gnt, d_gnt, if_ack, d_ack, ram_enable, ram_readWrite, busy};

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Issue a request on one or both ports; serve until every request is done.
  task automatic run_txn(input bit fr, input logic [AW-1:0] fa, input bit dr,
                         input bit dwe, input logic [AW-1:0] da, input logic [DW-1:0] dwd);
    bit pf, pd, w, we;
    logic [AW-1:0] a;
    logic [6:0] exp_st;
    pf = fr; pd = dr;
    @(negedge clk);
    if_req = fr; if_addr = fa; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    while (pf || pd) begin
      if (pf && pd) w = (last_served == 1'b0);
      else          w = pd;
      last_served = w;
      a  = w ? da : fa;
      we = w ? dwe : 1'b0;
      @(posedge clk); #1;
      exp_st = {!w, w, 1'b0, 1'b0, 1'b1, !we, 1'b1};
      n_total++;
      if (st !== exp_st) $display("FAIL txn_access_status: got %b want %b", st, exp_st);
      else n_pass++;
      n_total++;
      if (ram_address !== a) $display("FAIL txn_access_addr: got %h want %h", ram_address, a);
      else n_pass++;
      if (we) begin
        n_total++;
        if (ram_dataIn !== dwd) $display("FAIL txn_access_wdata: got %h want %h", ram_dataIn, dwd);
        else n_pass++;
        ref_mem[a] = dwd;
      end else begin
        exp_rdata = ref_mem[a];
      end
      @(negedge clk);
      if (w) begin d_req = 1'b0; pd = 1'b0; end
      else   begin if_req = 1'b0; pf = 1'b0; end
      @(posedge clk); #1;
      exp_st = {1'b0, 1'b0, !w, w, 1'b0, 1'b1, 1'b1};
      n_total++;
      if (st !== exp_st) $display("FAIL txn_resp_status: got %b want %b", st, exp_st);
      else n_pass++;
      n_total++;
      if (rdata !== exp_rdata) $display("FAIL txn_resp_rdata: got %h want %h", rdata, exp_rdata);
      else n_pass++;
      n_total++;
      if (ram_address !== a) $display("FAIL txn_resp_addr_hold: got %h want %h", ram_address, a);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (st !== 7'b0000010) $display("FAIL txn_idle_status: got %b want %b", st, 7'b0000010);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if_req = 1'b1; if_addr = 16'h0001; d_req = 1'b1; d_we = 1'b1;
    d_addr = 16'h0002; d_wdata = 32'h5555_AAAA;
    repeat (3) begin
      @(posedge clk); #1;
      n_total++;
      if (st !== 7'b0000010) $display("FAIL reset_status: got %b want %b", st, 7'b0000010);
      else n_pass++;
      n_total++;
      if ({ram_address, ram_dataIn, rdata} !== '0)
        $display("FAIL reset_values: got addr %h din %h rdata %h want zeros", ram_address, ram_dataIn, rdata);
      else n_pass++;
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0; reset = 1'b0;
    last_served = 1'b0; exp_rdata = '0;
    @(posedge clk); #1;
    n_total++;
    if (st !== 7'b0000010) $display("FAIL reset_release_idle: got %b want %b", st, 7'b0000010);
    else n_pass++;
  endtask

  task automatic test_fetch_read();
    preload(16'h0010, 32'hDEADBEEF);
    run_txn(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 32'h0);
    n_total++;
    if (rdata !== 32'hDEADBEEF) $display("FAIL fetch_read_rdata: got %h want %h", rdata, 32'hDEADBEEF);
    else n_pass++;
  endtask

  task automatic test_write_read();
    preload(16'h0100, 32'h0);
    run_txn(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 32'h12345678);
    n_total++;
    if (ram[16'h0100] !== 32'h12345678) $display("FAIL write_ram_content: got %h want %h", ram[16'h0100], 32'h12345678);
    else n_pass++;
    run_txn(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100, 32'h0);
    n_total++;
    if (rdata !== 32'h12345678) $display("FAIL write_then_read_rdata: got %h want %h", rdata, 32'h12345678);
    else n_pass++;
  endtask

  task automatic test_contention();
    bit g, ak, dt;
    logic [6:0] exp_st;
    preload(16'h0020, 32'h2020_2020);
    preload(16'h0030, 32'h3030_3030);
    reset = 1'b1;
    if_req = 1'b1; if_addr = 16'h0020;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      g  = (k <= 10) && (k % 3 == 1);
      ak = (k <= 11) && (k % 3 == 2);
      dt = (((k - 1) / 3) % 2) == 0;
      exp_st = {g && !dt, g && dt, ak && !dt, ak && dt, g, 1'b1, (k <= 11) && (k % 3 != 0)};
      n_total++;
      if (st !== exp_st) $display("FAIL contention_cycle_%0d: got %b want %b", k, st, exp_st);
      else n_pass++;
      if (k == 11) begin
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0;
      end
    end
    last_served = 1'b0;
    exp_rdata = ref_mem[16'h0020];
    n_total++;
    if (rdata !== exp_rdata) $display("FAIL contention_final_rdata: got %h want %h", rdata, exp_rdata);
    else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    preload(16'h0040, 32'hCAFEF00D);
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0040;
    @(posedge clk); #1;
    n_total++;
    if (st !== 7'b1000111) $display("FAIL midreset_access: got %b want %b", st, 7'b1000111);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1; if_req = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (st !== 7'b0000010) $display("FAIL midreset_abort_status: got %b want %b", st, 7'b0000010);
    else n_pass++;
    n_total++;
    if (rdata !== '0) $display("FAIL midreset_rdata: got %h want %h", rdata, 32'h0);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    last_served = 1'b0; exp_rdata = '0;
    @(posedge clk); #1;
    n_total++;
    if (st !== 7'b0000010) $display("FAIL midreset_no_late_ack: got %b want %b", st, 7'b0000010);
    else n_pass++;
    run_txn(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 32'h0);
  endtask

  task automatic test_boundary_late();
    preload(16'hFFFF, 32'hA5A5_5A5A);
    preload(16'h0200, 32'h7766_5544);
    run_txn(1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 32'h0BAD_F00D);
    run_txn(1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 32'h0);
    n_total++;
    if (rdata !== 32'h0BAD_F00D) $display("FAIL boundary_ffff_rdata: got %h want %h", rdata, 32'h0BAD_F00D);
    else n_pass++;
    // Data request raised during a fetch's ACCESS cycle must wait for IDLE.
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'hFFFF;
    @(posedge clk); #1;
    n_total++;
    if (st !== 7'b1000111) $display("FAIL late_fetch_access: got %b want %b", st, 7'b1000111);
    else n_pass++;
    last_served = 1'b0;
    exp_rdata = ref_mem[16'hFFFF];
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
    @(posedge clk); #1;
    n_total++;
    if (st !== 7'b0010011) $display("FAIL late_resp_no_dgnt: got %b want %b", st, 7'b0010011);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (st !== 7'b0000010) $display("FAIL late_idle_no_dgnt: got %b want %b", st, 7'b0000010);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (st !== 7'b0100111 || ram_address !== 16'h0200)
      $display("FAIL late_data_access: got %b/%h want %b/%h", st, ram_address, 7'b0100111, 16'h0200);
    else n_pass++;
    last_served = 1'b1;
    exp_rdata = ref_mem[16'h0200];
    @(negedge clk);
    d_req = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (st !== 7'b0001011 || rdata !== exp_rdata)
      $display("FAIL late_data_resp: got %b/%h want %b/%h", st, rdata, 7'b0001011, exp_rdata);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [AW-1:0] pool [8] = '{16'h0000, 16'h0001, 16'h0010, 16'h0100,
                                16'h1234, 16'h8000, 16'hFFFE, 16'hFFFF};
    bit fr, dr, we;
    for (int i = 0; i < 8; i++) preload(pool[i], $urandom);
    for (int t = 0; t < 40; t++) begin
      fr = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      if (!fr && !dr) dr = 1'b1;
      we = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_txn(fr, pool[$urandom_range(0, 7)], dr, we, pool[$urandom_range(0, 7)], $urandom);
    end
  endtask

  initial begin
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    last_served = 1'b0; exp_rdata = '0;
    test_reset();
    test_fetch_read();
    test_write_read();
    test_contention();
    test_reset_mid_access();
    test_boundary_late();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, RAM word-address width.
REQ-002 Parameter DATA_W, default 32, RAM data width.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-005 if_req  in  1  fetch port read request, level.
REQ-006 if_addr  in  ADDR_W  fetch word address.
REQ-007 if_gnt  out  1  fetch request accepted, one-cycle pulse.
REQ-008 if_ack  out  1  fetch read data valid on rdata, one-cycle pulse.
REQ-009 d_req  in  1  data port request, level.
REQ-010 d_we  in  1  data port: 1 = write, 0 = read.
REQ-011 d_addr  in  ADDR_W  data word address.
REQ-012 d_wdata  in  DATA_W  data port write data.
REQ-013 d_gnt  out  1  data request accepted, one-cycle pulse.
REQ-014 d_ack  out  1  data access complete (read data valid, or write done), one-cycle pulse.
REQ-015 rdata  out  DATA_W  captured read data, shared by both ports.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 ram_enable  out  1  RAM enable.
REQ-018 ram_readWrite  out  1  RAM direction: 1 = read, 0 = write.
REQ-019 ram_address  out  ADDR_W  RAM address.
REQ-020 ram_dataIn  out  DATA_W  RAM write data.
REQ-021 ram_dataOut  in  DATA_W  RAM read data.

Function
REQ-022 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-023 Transitions SHALL be IDLE->ACCESS when if_req or d_req is high, ACCESS->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-024 Requests SHALL be sampled only in IDLE; requests seen in ACCESS or RESP SHALL be ignored.
REQ-025 On acceptance, the block SHALL latch the owner, address, we and wdata.
REQ-026 A fetch port acceptance SHALL latch we=0.
REQ-027 All outputs SHALL be registered.
REQ-028 When only one port requests in IDLE, that port SHALL win.
REQ-029 When both ports request in IDLE, the port not served most recently SHALL win; last_owner updates on every acceptance.
REQ-030 Given an acceptance edge ending cycle 0, cycle 1 SHALL be ACCESS with the winner's gnt high for that cycle only.
REQ-031 In ACCESS, ram_enable=1, ram_readWrite=~we, and ram_address/ram_dataIn SHALL equal the latched values.
REQ-032 In ACCESS, the block SHALL capture ram_dataOut into rdata at the end of the cycle for reads only; writes SHALL leave rdata unchanged.
REQ-033 Cycle 2 SHALL be RESP with the owner's ack high for that cycle only and ram_enable=0.
REQ-034 Read data SHALL be valid on rdata in cycle 2 and held until the next read capture.
REQ-035 Outside ACCESS, ram_enable SHALL be 0 and ram_readWrite SHALL be 1; ram_address and ram_dataIn SHALL hold their last values.
REQ-036 A requester SHALL keep req and its inputs stable until gnt, and SHALL drop req no later than its ack cycle; req still high in the following IDLE is a new request.
REQ-037 Throughput SHALL be one access per 3 cycles; at most one gnt and one ack SHALL be high in any cycle, and gnt and ack SHALL never be high together.
REQ-038 Address arithmetic: none; addresses SHALL pass through unmodified at full ADDR_W, including 16'hFFFF.

Reset
REQ-039 While reset is high, the block SHALL force state=IDLE.
REQ-040 While reset is high, the block SHALL hold all gnt/ack low, busy=0, ram_enable=0, ram_readWrite=1, ram_address=0, ram_dataIn=0 and rdata=0.
REQ-041 While reset is high, the block SHALL set last_owner=FETCH, so the data port wins the first contention.
REQ-042 Reset asserted in ACCESS or RESP SHALL abort the access: no ack, no rdata update, and ram_enable=0 from the next cycle.
REQ-043 The first request SHALL be sampled in the first IDLE cycle after reset deasserts.

Structure
REQ-044 Package mem_arb_pkg SHALL hold the state enum, the owner encoding (FETCH=0, DATA=1) and the ADDR_W/DATA_W defaults.
REQ-045 The block SHALL contain one sub-module, rr_arb2: a combinational two-way round-robin picker (inputs req[1:0] and last_owner; output winner).

Verification
REQ-046 Single fetch read: Mem[16'h0010]=32'hDEADBEEF, if_req with if_addr=16'h0010 -> if_gnt cycle 1, ram_enable=1/readWrite=1 in cycle 1, if_ack with rdata=32'hDEADBEEF in cycle 2.
REQ-047 Data write then read: d_we=1, d_addr=16'h0100, d_wdata=32'h12345678 -> one ram_enable cycle with readWrite=0 and d_ack one cycle later; next read of 16'h0100 -> rdata=32'h12345678.
REQ-048 Contention: both ports hold req from reset release -> grant order DATA, FETCH, DATA, FETCH, with a gnt every 3 cycles and no starvation.
REQ-049 Reset mid-access: reset in the ACCESS cycle of a read -> no ack, rdata=0, ram_enable=0 next cycle, and a fresh request completes normally.
REQ-050 Boundary address and late requests: access at 16'hFFFF returns correct data; a d_req raised in ACCESS is not served until the following IDLE.
